// File: rtl/mem_align_unit.sv
// Load/store alignment stage: maps a byte-addressed request onto a word memory
// with byte enables, splitting accesses that straddle a word boundary.
module mem_align_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic [2:0]        req_fun3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [2:0]        rsp_fun3,
    output logic              rsp_misaligned,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC0 = 2'd1;
    localparam logic [1:0] ACC1 = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]        state;
    logic              load_q;
    logic [2:0]        fun3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       acc_q;

    logic [1:0]        off;
    logic [3:0]        size_be;
    logic [31:0]       size_mask;
    logic [7:0]        be_span;
    logic [63:0]       wdata_span;
    logic              split;
    logic [ADDR_W-3:0] word0;
    logic [ADDR_W-3:0] word1;
    logic [5:0]        hi_shift;

    assign off = addr_q[1:0];

    always_comb begin
        size_be   = 4'b1111;
        size_mask = '1;
        case (fun3_q[1:0])
            2'b00: begin size_be = 4'b0001; size_mask = 32'h0000_00FF; end
            2'b01: begin size_be = 4'b0011; size_mask = 32'h0000_FFFF; end
            default: ;
        endcase
    end

    // Shifting into a double-width span yields both words at once: the low half
    // is the first access, the high half is whatever spilled into the next word.
    assign be_span    = {4'b0000, size_be} << off;
    assign wdata_span = {32'h0, wdata_q} << {off, 3'b000};
    assign split      = |be_span[7:4];
    assign hi_shift   = 6'd32 - {1'b0, off, 3'b000};

    assign word0 = addr_q[ADDR_W-1:2];
    assign word1 = word0 + {{(ADDR_W-3){1'b0}}, 1'b1};

    assign req_ready      = (state == IDLE);
    assign rsp_valid      = (state == DONE);
    assign rsp_rdata      = acc_q & size_mask;
    assign rsp_fun3       = fun3_q;
    assign rsp_misaligned = split;

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == ACC0) begin
            mem_req   = 1'b1;
            mem_we    = ~load_q;
            mem_be    = be_span[3:0];
            mem_addr  = {word0, 2'b00};
            mem_wdata = wdata_span[31:0];
        end else if (state == ACC1) begin
            mem_req   = 1'b1;
            mem_we    = ~load_q;
            mem_be    = be_span[7:4];
            mem_addr  = {word1, 2'b00};
            mem_wdata = wdata_span[63:32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            load_q  <= 1'b0;
            fun3_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            acc_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        load_q  <= req_load;
                        fun3_q  <= req_fun3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        acc_q   <= '0;
                        state   <= ACC0;
                    end
                end
                ACC0: begin
                    if (mem_ack) begin
                        if (load_q) acc_q <= mem_rdata >> {off, 3'b000};
                        state <= split ? ACC1 : DONE;
                    end
                end
                ACC1: begin
                    if (mem_ack) begin
                        if (load_q) acc_q <= acc_q | (mem_rdata << hi_shift);
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_align_unit.md
Name: mem_align_unit

Overview:
- Data-memory access stage directly upstream of the load sign/zero-extension logic.
- Accepts one load/store request from the pipeline and drives a 32-bit word-addressed memory with byte enables.
- Splits misaligned halfword/word accesses into two word transactions.
- Returns load data right-aligned (selected bytes in bits [7:0]/[15:0]/[31:0]) together with fun3, ready for the extension stage.

Parameters:
- ADDR_W, 32, request/memory address width (byte address).

Ports:
- clk  in  1  system clock; one clock domain; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  pipeline request present.
- req_ready  out  1  unit idle, request accepted this cycle if req_valid.
- req_load  in  1  1=load, 0=store.
- req_fun3  in  3  RISC-V fun3; [1:0] gives size: 00 byte, 01 half, 10/11 word.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse (loads and stores).
- rsp_rdata  out  32  right-aligned raw load data; bytes above access size are 0; 0 for stores.
- rsp_fun3  out  3  captured fun3, for the extension stage.
- rsp_misaligned  out  1  access was split; valid with rsp_valid.
- mem_req  out  1  memory request.
- mem_we  out  1  write enable.
- mem_be  out  4  byte enables.
- mem_addr  out  ADDR_W  word-aligned address ([1:0]=0).
- mem_wdata  out  32  lane-aligned write data.
- mem_rdata  in  32  read word, valid when mem_ack=1.
- mem_ack  in  1  memory completes the current request.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: req_ready=1; all other outputs 0; state=IDLE.
- FSM states: IDLE, ACC0, ACC1, DONE.
- IDLE: req_ready=1 (decoded from state). On req_valid, capture load, fun3, addr, wdata; go to ACC0.
- ACC0: mem_req=1 with first-word signals. On mem_ack: go to ACC1 if split, else DONE.
- ACC1: mem_req=1 with second-word signals. On mem_ack, go to DONE.
- DONE: rsp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in every state except IDLE.
- Sizing and offsets: n = 1, 2 or 4 bytes; off = addr[1:0]; A = {addr[ADDR_W-1:2], 2'b00}.
- Split condition: off+n > 4 (half at off=3; word at off=1,2,3).
- First access: addr A; be0 = (((1<<n)-1)<<off) & 4'hF; wdata = wdata << 8*off.
- Second access: addr A+4 modulo 2^ADDR_W, so 0xFFFFFFFC wraps to 0x00000000; be1 = ((1<<n)-1) >> (4-off); wdata = wdata >> 8*(4-off).
- Load assembly:
  - On the ACC0 ack, store rdata >> 8*off.
  - On the ACC1 ack, OR in rdata << 8*(4-off).
  - Mask to n bytes before presenting; rsp_rdata is held until the next acceptance.
- mem_we = ~load in both accesses.
- mem_req/addr/we/be/wdata remain stable while mem_req=1 and mem_ack=0 (any number of wait states).
- mem_ack is ignored while mem_req=0.
- Back-to-back split: ACC0 ack to ACC1 leaves mem_req high continuously; only addr/be/wdata change.
- Latency with zero-wait memory (ack in the first mem_req cycle), counted from the acceptance edge:
  - mem_req asserts the next cycle.
  - rsp_valid asserts 2 cycles after acceptance for aligned accesses, 3 for split.
  - Each wait state adds 1 cycle.
- Reset mid-operation: the transaction is aborted. mem_req drops immediately (asynchronously), no rsp_valid, and the unit returns to IDLE with req_ready=1.
- Store response: rsp_rdata=0; rsp_fun3 and rsp_misaligned are still valid.

Test Plan:
- LW 0x100, mem word 0xDEADBEEF, immediate ack -> one access: addr 0x100, be 1111. rsp_rdata=0xDEADBEEF, rsp_misaligned=0, rsp_valid 2 cycles after accept.
- LB 0x103, word 0x88776655 -> be 1000; rsp_rdata=0x00000088; rsp_fun3=000.
- Misaligned LW 0x102; word@0x100=0x44332211, word@0x104=0x88776655 -> be 1100 @0x100, then be 0011 @0x104 with mem_req continuous. rsp_rdata=0x66554433; rsp_misaligned=1; rsp_valid 3 cycles after accept.
- SH 0x1FF, wdata 0x0000ABCD -> access @0x1FC: we=1, be 1000, wdata[31:24]=0xCD. Then @0x200: be 0001, wdata[7:0]=0xAB.
- Wait states: LHU 0x202 with ack delayed 3 cycles -> addr 0x200, be 1100 stable all 4 cycles; req_ready=0; no rsp_valid until 1 cycle after ack.
- SW 0xFFFFFFFE -> second access at 0x00000000, be 0011. Separately, assert rst_n=0 during ACC1 -> mem_req=0 the same cycle, req_ready=1, no rsp_valid.
